branch_resolve: RTL

//  Write/resolve side of the branch target buffer (BTB). Holds fetch-time predictions in an in-order queue.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/pred_queue.sv | 78 +++++++
 rtl/branch_resolve.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Purpose:      shared types and constants for the branch-resolve slice.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
package bp_pkg;

  // Address width of the slice. The queue entry type is built from it,
  // so every module of the slice shares this single value.
  localparam int XLEN = 64;

  // Fall-through distance: every instruction is one fixed-size word.
  localparam int INSTR_BYTES = 4;

  // One fetch-time prediction: the instruction PC and the PC that fetch
  // went to next.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred;
  } pq_entry_t;

  // RUN: normal resolve. FLUSH: one dead cycle after a redirect while
  // fetch restarts; nothing is pushed or popped.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/pred_queue.sv
// Purpose:      in-order FIFO of fetch-time predictions with a one-shot clear.
// Latency:      a pushed entry can be the head (and be popped) the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   push, push_dat  write one entry at the tail
//   pop             consume the head entry
//   clear           discard every entry (pointers back to zero)
//   head_dat        oldest entry (valid when !empty)
//   full, empty     occupancy flags
module pred_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  pq_entry_t push_dat,
  input  logic      pop,
  input  logic      clear,
  output pq_entry_t head_dat,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit: equal low bits with differing top bits means full.
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  pq_entry_t     mem_q [DEPTH];

  logic wr_en;
  logic rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Full is judged on the registered pointers, so a same-cycle pop never
  // makes room for a push into a full queue.
  assign wr_en = push && !full && !clear;
  assign rd_en = pop && !empty && !clear;

  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // Pointers wrap naturally modulo 2*DEPTH.
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only observed between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/branch_resolve.sv
// Purpose:      resolve queued fetch predictions against execute outcomes; redirect fetch and train the BTB.
// Latency:      redirect/result pulses are registered, one cycle after the resolving pop.
// Backpressure: pq_ready drops when the queue is full or during the one-cycle FLUSH; res_ready needs a queued entry and RUN.
//
// Ports:
//   clk, reset                          clock, async active-low reset
//   pq_push/pq_pc/pq_pred/pq_ready      prediction push from fetch
//   res_valid/res_is_branch/res_taken/
//   res_target/res_ready                outcome of the oldest instruction from execute
//   redirect_valid/redirect_pc          one-cycle fetch restart
//   result_cyc/result_addr/result_target one-cycle BTB write
//   mispredict_cnt                      saturating mispredict count
module branch_resolve
  import bp_pkg::*;
#(
  parameter int PQ_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pq_push,
  input  logic [XLEN-1:0] pq_pc,
  input  logic [XLEN-1:0] pq_pred,
  output logic            pq_ready,
  input  logic            res_valid,
  input  logic            res_is_branch,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            res_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            result_cyc,
  output logic [XLEN-1:0] result_addr,
  output logic [XLEN-1:0] result_target,
  output logic [31:0]     mispredict_cnt
);

  br_state_t state_q, state_d;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            result_cyc_q, result_cyc_d;
  logic [XLEN-1:0] result_addr_q, result_addr_d;
  logic [XLEN-1:0] result_target_q, result_target_d;
  logic [31:0]     cnt_q, cnt_d;

  pq_entry_t       head;
  pq_entry_t       push_entry;
  logic            q_full;
  logic            q_empty;
  logic            pop_en;
  logic            push_en;
  logic            taken_br;
  logic [XLEN-1:0] actual_next;
  logic            mispredict;

  assign pq_ready  = !q_full && (state_q == RUN);
  assign res_ready = !q_empty && (state_q == RUN);

  assign pop_en   = res_valid && res_ready;
  assign taken_br = res_is_branch && res_taken;

  // Anything that is not a taken control transfer falls through.
  assign actual_next = taken_br ? res_target : (head.pc + XLEN'(INSTR_BYTES));
  assign mispredict  = pop_en && (actual_next != head.pred);

  // A push alongside a mispredict is on the wrong path and is discarded.
  assign push_en = pq_push && pq_ready && !mispredict;

  assign push_entry.pc   = pq_pc;
  assign push_entry.pred = pq_pred;

  pred_queue #(
    .DEPTH (PQ_DEPTH)
  ) u_pred_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push_en),
    .push_dat (push_entry),
    .pop      (pop_en),
    .clear    (mispredict),
    .head_dat (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // FSM: a mispredict buys exactly one quiet cycle for fetch to restart.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output pulses: recomputed every cycle so they are zero unless the
  // previous cycle resolved a mispredict.
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    result_cyc_d     = 1'b0;
    result_addr_d    = '0;
    result_target_d  = '0;
    cnt_d            = cnt_q;
    if (mispredict) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = actual_next;
      // Only a taken branch the BTB got wrong needs a (re)write; a
      // not-taken branch never allocates.
      if (taken_br) begin
        result_cyc_d    = 1'b1;
        result_addr_d   = head.pc;
        result_target_d = res_target;
      end
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      result_cyc_q     <= 1'b0;
      result_addr_q    <= '0;
      result_target_q  <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      result_cyc_q     <= result_cyc_d;
      result_addr_q    <= result_addr_d;
      result_target_q  <= result_target_d;
      cnt_q            <= cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign result_cyc     = result_cyc_q;
  assign result_addr    = result_addr_q;
  assign result_target  = result_target_q;
  assign mispredict_cnt = cnt_q;

endmodule
